// File: rtl/kugelblitz_rewrite_ctrl.sv
// kugelblitz_rewrite_ctrl
// Rule-table controller for the kugelblitz byte-rewrite datapath on one port.
// A shadow table is loaded through a simple write port. It is copied to the
// active table only when no frame is open, so one frame always sees a single
// consistent rule set. The active table and the current beat index produce a
// per-lane select mask and lane-aligned replacement bytes for the datapath.

module kugelblitz_rewrite_ctrl #(
    parameter int RULE_COUNT   = 4,
    parameter int OFFSET_WIDTH = 16,
    parameter int KEEP_WIDTH   = 64,
    parameter int BEAT_WIDTH   = OFFSET_WIDTH - $clog2(KEEP_WIDTH),
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      cfg_wr_valid,
    output logic                      cfg_wr_ready,
    input  logic [3:0]                cfg_wr_idx,
    input  logic [OFFSET_WIDTH-1:0]   cfg_wr_offset,
    input  logic [7:0]                cfg_wr_data,
    input  logic                      cfg_wr_enable,
    input  logic                      cfg_commit,
    output logic                      commit_pending,
    output logic                      commit_done,

    input  logic                      mon_tvalid,
    input  logic                      mon_tready,
    input  logic                      mon_tlast,
    output logic                      in_frame,
    output logic [BEAT_WIDTH-1:0]     beat_index,

    output logic [KEEP_WIDTH-1:0]     byte_sel,
    output logic [KEEP_WIDTH*8-1:0]   byte_data,
    output logic [COUNT_WIDTH-1:0]    frame_count
);

    localparam int LANE_W = $clog2(KEEP_WIDTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t                   state_q;
    logic [BEAT_WIDTH-1:0]    beat_index_q;
    logic                     commit_pending_q;
    logic                     commit_done_q;
    logic [COUNT_WIDTH-1:0]   frame_count_q;

    logic                     shadowEn_q   [RULE_COUNT];
    logic [OFFSET_WIDTH-1:0]  shadowOff_q  [RULE_COUNT];
    logic [7:0]               shadowData_q [RULE_COUNT];
    logic                     shadowEn_d   [RULE_COUNT];
    logic [OFFSET_WIDTH-1:0]  shadowOff_d  [RULE_COUNT];
    logic [7:0]               shadowData_d [RULE_COUNT];

    logic                     activeEn_q   [RULE_COUNT];
    logic [OFFSET_WIDTH-1:0]  activeOff_q  [RULE_COUNT];
    logic [7:0]               activeData_q [RULE_COUNT];

    logic                     beat;
    logic                     last;
    logic                     openBeat;
    logic                     wrAccept;
    logic                     commitReq;
    logic                     boundaryOk;
    logic                     applyNow;
    logic                     anyActive;

    logic [KEEP_WIDTH-1:0]    byteSel;
    logic [KEEP_WIDTH*8-1:0]  byteData;
    logic [LANE_W-1:0]        lane;

    // Handshake decode of the monitored stream.
    assign beat     = mon_tvalid & mon_tready;
    assign last     = beat & mon_tlast;
    assign openBeat = beat & ~mon_tlast;

    // Writes are held off while a commit waits, so the pending snapshot
    // cannot be modified behind the requester's back.
    assign wrAccept = cfg_wr_valid & ~commit_pending_q;

    // A commit may land at the end of any cycle after which no frame is
    // open: idle without a frame starting, or on the closing beat.
    assign commitReq  = cfg_commit | commit_pending_q;
    assign boundaryOk = ((state_q == ST_IDLE) & ~openBeat) |
                        ((state_q == ST_FRAME) & last);
    assign applyNow   = commitReq & boundaryOk;

    // Reduce the active enables; frames only count while some rule is live.
    always_comb begin
        anyActive = 1'b0;
        for (int r = 0; r < RULE_COUNT; r++) begin
            anyActive = anyActive | activeEn_q[r];
        end
    end

    // Next shadow contents, including this cycle's write, so a write issued
    // with a commit is carried into the active set.
    always_comb begin
        shadowEn_d   = shadowEn_q;
        shadowOff_d  = shadowOff_q;
        shadowData_d = shadowData_q;
        for (int r = 0; r < RULE_COUNT; r++) begin
            if (wrAccept && (cfg_wr_idx == 4'(r))) begin
                shadowEn_d[r]   = cfg_wr_enable;
                shadowOff_d[r]  = cfg_wr_offset;
                shadowData_d[r] = cfg_wr_data;
            end
        end
    end

    // Shadow and active rule storage; active only loads at a safe boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < RULE_COUNT; r++) begin
                shadowEn_q[r]   <= 1'b0;
                shadowOff_q[r]  <= '0;
                shadowData_q[r] <= '0;
                activeEn_q[r]   <= 1'b0;
                activeOff_q[r]  <= '0;
                activeData_q[r] <= '0;
            end
        end else begin
            shadowEn_q   <= shadowEn_d;
            shadowOff_q  <= shadowOff_d;
            shadowData_q <= shadowData_d;
            if (applyNow) begin
                activeEn_q   <= shadowEn_d;
                activeOff_q  <= shadowOff_d;
                activeData_q <= shadowData_d;
            end
        end
    end

    // Frame tracker, beat counter, commit handshake and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            beat_index_q     <= '0;
            commit_pending_q <= 1'b0;
            commit_done_q    <= 1'b0;
            frame_count_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (openBeat) begin
                        state_q <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (last) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            if (last) begin
                beat_index_q <= '0;
            end else if (beat && (beat_index_q != {BEAT_WIDTH{1'b1}})) begin
                beat_index_q <= beat_index_q + 1'b1;
            end

            commit_done_q    <= applyNow;
            commit_pending_q <= commitReq & ~boundaryOk;

            if (last && anyActive) begin
                frame_count_q <= frame_count_q + 1'b1;
            end
        end
    end

    // Lane decode of the active table for the current beat. Rules are
    // visited from the highest index down so the lowest index lands last
    // and wins any overlap.
    always_comb begin
        byteSel  = '0;
        byteData = '0;
        lane     = '0;
        for (int r = RULE_COUNT - 1; r >= 0; r--) begin
            if (activeEn_q[r] &&
                (activeOff_q[r][OFFSET_WIDTH-1:LANE_W] == beat_index_q)) begin
                lane                             = activeOff_q[r][LANE_W-1:0];
                byteSel[lane]                    = 1'b1;
                byteData[{lane, 3'b000} +: 8]    = activeData_q[r];
            end
        end
    end

    assign cfg_wr_ready   = ~commit_pending_q;
    assign commit_pending = commit_pending_q;
    assign commit_done    = commit_done_q;
    assign in_frame       = (state_q == ST_FRAME);
    assign beat_index     = beat_index_q;
    assign frame_count    = frame_count_q;
    assign byte_sel       = byteSel;
    assign byte_data      = byteData;

endmodule
